// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
// Holds the FSM state encoding, operation codes and index sizing.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int words);
        if (words > 1) begin
            return $clog2(words);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/adder_multiword_seq_if.sv
// Operand/result handshake bundle between producer, sequencer and consumer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface adder_multiword_seq_if #(
    parameter int W = 16
) ();

    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         OP;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] RESULT;
    logic         C_OUT;
    logic         OVERFLOW;
    logic         BUSY;

    modport slave (
        input  IN_VALID, A, B, OP, OUT_READY,
        output IN_READY, OUT_VALID, RESULT, C_OUT, OVERFLOW, BUSY
    );

    modport master (
        output IN_VALID, A, B, OP, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT, C_OUT, OVERFLOW, BUSY
    );

endinterface

// File: rtl/ADDER_FULL.sv
// Nbits-wide ripple-carry adder with carry-in, carry-out and signed overflow.
// Overflow compares the carries into and out of the most significant bit.
module ADDER_FULL #(
    parameter int Nbits = 4
) (
    input  logic [Nbits-1:0] A,
    input  logic [Nbits-1:0] B,
    input  logic             C_IN,
    output logic [Nbits-1:0] SUM,
    output logic             C_OUT,
    output logic             OVERFLOW
);

    logic [Nbits:0] carry_s;

    assign carry_s[0] = C_IN;

    for (genvar i = 0; i < Nbits; i++) begin : g_bit
        assign SUM[i]         = A[i] ^ B[i] ^ carry_s[i];
        assign carry_s[i + 1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
    end

    assign C_OUT    = carry_s[Nbits];
    assign OVERFLOW = carry_s[Nbits] ^ carry_s[Nbits - 1];

endmodule

// File: rtl/adder_multiword_seq.sv
// Wide add/subtract built by stepping one Nbits adder across WORDS chunks, LSB first.
// The chunk carry is chained through carry_q; results are held until the consumer takes them.
module adder_multiword_seq
    import adder_seq_pkg::*;
#(
    parameter int Nbits = 4,
    parameter int WORDS = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    adder_multiword_seq_if.slave bus
);

    localparam int W  = Nbits * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    result_q, result_d;
    logic            c_out_q, c_out_d;
    logic            ovf_q, ovf_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [Nbits-1:0] a_chunk_s;
    logic [Nbits-1:0] b_chunk_s;
    logic [Nbits-1:0] sum_chunk_s;
    logic             add_cout_s;
    logic             add_ovf_s;

    // Present the current chunk of the latched operands to the shared adder.
    always_comb begin
        a_chunk_s = a_q[idx_q * Nbits +: Nbits];
        b_chunk_s = b_q[idx_q * Nbits +: Nbits];
    end

    ADDER_FULL #(
        .Nbits (Nbits)
    ) u_adder (
        .A        (a_chunk_s),
        .B        (b_chunk_s),
        .C_IN     (carry_q),
        .SUM      (sum_chunk_s),
        .C_OUT    (add_cout_s),
        .OVERFLOW (add_ovf_s)
    );

    // Next-state and datapath updates for the IDLE/RUN/HOLD sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.IN_VALID && in_ready_q) begin
                    a_d     = bus.A;
                    // Subtraction is A + ~B + 1: invert B here, the +1 enters as the first carry.
                    b_d     = (bus.OP == OP_SUB) ? ~bus.B : bus.B;
                    carry_d = bus.OP;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[idx_q * Nbits +: Nbits] = sum_chunk_s;
                carry_d                          = add_cout_s;
                if (idx_q == LAST_IDX) begin
                    c_out_d = add_cout_s;
                    ovf_d   = add_ovf_s;
                    state_d = HOLD;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RUN;
                end
            end
            HOLD: begin
                if (bus.OUT_READY) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are decoded from the next state so they stay registered.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d == RUN) || (state_d == HOLD);
    end

    // State, operand, carry and result registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.RESULT    = result_q;
    assign bus.C_OUT     = c_out_q;
    assign bus.OVERFLOW  = ovf_q;
    assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_adder_multiword_seq.sv
// Directed bench for adder_multiword_seq with Nbits=4, WORDS=4 (16-bit operations).
module tb_adder_multiword_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    adder_multiword_seq_if #(.W(16)) bus ();

    adder_multiword_seq #(
        .Nbits (4),
        .WORDS (4)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for OUT_VALID; returns edges counted since the call.
    task automatic wait_out_valid(input string tag, output int edges);
        edges = 0;
        while (bus.OUT_VALID !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq({tag, "_outvalid_seen"}, {31'd0, bus.OUT_VALID}, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic op, input logic [15:0] er, input logic ec, input logic ev);
        int edges;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, {31'd0, bus.IN_READY}, 32'd1);
        bus.A         = a;
        bus.B         = b;
        bus.OP        = op;
        bus.IN_VALID  = 1'b1;
        bus.OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
        bus.A        = 16'hDEAD;
        bus.B        = 16'hBEEF;
        bus.OP       = ~op;
        wait_out_valid(tag, edges);
        check_eq({tag, "_latency"}, edges, 32'd4);
        check_eq({tag, "_result"}, {16'd0, bus.RESULT}, {16'd0, er});
        check_eq({tag, "_c_out"}, {31'd0, bus.C_OUT}, {31'd0, ec});
        check_eq({tag, "_overflow"}, {31'd0, bus.OVERFLOW}, {31'd0, ev});
        check_eq({tag, "_busy_hold"}, {31'd0, bus.BUSY}, 32'd1);
        check_eq({tag, "_in_ready_hold"}, {31'd0, bus.IN_READY}, 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_outvalid_drop"}, {31'd0, bus.OUT_VALID}, 32'd0);
        check_eq({tag, "_in_ready_back"}, {31'd0, bus.IN_READY}, 32'd1);
        check_eq({tag, "_busy_idle"}, {31'd0, bus.BUSY}, 32'd0);
    endtask

    initial begin
        int edges;
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.A         = 16'h0000;
        bus.B         = 16'h0000;
        bus.OP        = 1'b0;
        bus.OUT_READY = 1'b1;
        #12;
        check_eq("rst_in_ready", {31'd0, bus.IN_READY}, 32'd1);
        check_eq("rst_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        check_eq("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        check_eq("rst_result", {16'd0, bus.RESULT}, 32'd0);
        check_eq("rst_c_out", {31'd0, bus.C_OUT}, 32'd0);
        check_eq("rst_overflow", {31'd0, bus.OVERFLOW}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        do_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("sub_8000", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_0005", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Backpressure: result held for 5 cycles while a second request waits.
        @(negedge clk);
        bus.A         = 16'h1000;
        bus.B         = 16'h0234;
        bus.OP        = 1'b0;
        bus.IN_VALID  = 1'b1;
        bus.OUT_READY = 1'b0;
        @(posedge clk);
        #1;
        bus.A  = 16'h0001;
        bus.B  = 16'h0001;
        bus.OP = 1'b0;
        wait_out_valid("bp", edges);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_outvalid_stable", {31'd0, bus.OUT_VALID}, 32'd1);
            check_eq("bp_result_stable", {16'd0, bus.RESULT}, 32'h1234);
            check_eq("bp_in_ready_low", {31'd0, bus.IN_READY}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_outvalid", {31'd0, bus.OUT_VALID}, 32'd0);
        check_eq("bp_release_in_ready", {31'd0, bus.IN_READY}, 32'd1);
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
        check_eq("bp_second_accepted", {31'd0, bus.IN_READY}, 32'd0);
        wait_out_valid("bp2", edges);
        check_eq("bp2_latency", edges, 32'd4);
        check_eq("bp2_result", {16'd0, bus.RESULT}, 32'h0002);
        @(posedge clk);
        #1;

        // Reset while RUN is working on chunk index 2.
        @(negedge clk);
        bus.A        = 16'hAAAA;
        bus.B        = 16'h1111;
        bus.OP       = 1'b0;
        bus.IN_VALID = 1'b1;
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        check_eq("midrst_in_ready", {31'd0, bus.IN_READY}, 32'd1);
        check_eq("midrst_busy", {31'd0, bus.BUSY}, 32'd0);
        check_eq("midrst_result", {16'd0, bus.RESULT}, 32'd0);
        check_eq("midrst_c_out", {31'd0, bus.C_OUT}, 32'd0);
        check_eq("midrst_overflow", {31'd0, bus.OVERFLOW}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_eq("midrst_no_result", {31'd0, bus.OUT_VALID}, 32'd0);
        end
        do_op("add_1234", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
